// File: rtl/bp_pkg.sv
// Shared encodings and saturating next-value helper for the branch predictor table.
package bp_pkg;

    // 2-bit counter encodings
    localparam logic [1:0] SNT = 2'd0;
    localparam logic [1:0] WNT = 2'd1;
    localparam logic [1:0] WT  = 2'd2;
    localparam logic [1:0] ST  = 2'd3;

    // Saturating step of a counter whose maximum value is ctr_max.
    // Computed at 32 bits so any CTR_W below 32 can share it.
    function automatic logic [31:0] sat_next(input logic [31:0] ctr,
                                             input logic [31:0] ctr_max,
                                             input logic        taken);
        logic [31:0] nxt;
        nxt = ctr;
        if (taken) begin
            if (ctr != ctr_max) nxt = ctr + 32'd1;
        end else begin
            if (ctr != 32'd0) nxt = ctr - 32'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// Next-value logic of one saturating direction counter (no storage).
module bp_sat_counter
    import bp_pkg::*;
#(
    parameter int CTR_W = 2
) (
    input  logic [CTR_W-1:0] ctr,
    input  logic             taken,
    output logic [CTR_W-1:0] nxt
);

    localparam logic [31:0] CTR_MAX = (32'd1 << CTR_W) - 32'd1;

    logic [31:0] nxt_wide;

    // Increment on taken, decrement otherwise, clamped at both ends
    always_comb begin
        nxt_wide = sat_next(32'(ctr), CTR_MAX, taken);
        nxt      = nxt_wide[CTR_W-1:0];
    end

endmodule

// File: rtl/branch_predictor_table.sv
// Table of ENTRIES saturating direction counters indexed by PC.
// Combinational predict port, registered update port, no read/write bypass.
// Optional gshare indexing enabled by defining BP_GSHARE_EN.
module branch_predictor_table
    import bp_pkg::*;
#(
    parameter int ENTRIES = 64,
    parameter int CTR_W   = 2,
    parameter int HIST_W  = 6,
    localparam int IDX_W  = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [31:0]      pred_pc,
    output logic             pred_taken,
    output logic [IDX_W-1:0] pred_idx,
    output logic [CTR_W-1:0] pred_ctr,
    input  logic             upd_valid,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_taken
);

    // Elaboration-time sanity on the parameter set
    if (ENTRIES < 2 || (1 << IDX_W) != ENTRIES) begin : g_bad_entries
        $error("ENTRIES must be a power of two, at least 2");
    end
    if (CTR_W < 1 || CTR_W > 31) begin : g_bad_ctr_w
        $error("CTR_W must be between 1 and 31");
    end
    if (HIST_W < 1 || HIST_W > IDX_W) begin : g_bad_hist_w
        $error("HIST_W must be between 1 and IDX_W");
    end

    logic [CTR_W-1:0] ctr_q [ENTRIES];
    logic [CTR_W-1:0] upd_cur;
    logic [CTR_W-1:0] upd_nxt;
    logic [IDX_W-1:0] pc_idx;

    // PC bits outside the index slice carry no information for the table
    logic unused_pc;
    assign unused_pc = ^{pred_pc[31:IDX_W+2], pred_pc[1:0]};

    assign pc_idx = pred_pc[IDX_W+1:2];

`ifdef BP_GSHARE_EN
    logic [HIST_W-1:0] ghr_q;

    // Global history: shift in each resolved outcome, oldest bit falls off
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ghr_q <= '0;
        end else if (upd_valid) begin
            if (HIST_W == 1) ghr_q <= HIST_W'(upd_taken);
            else             ghr_q <= HIST_W'({ghr_q, upd_taken});
        end
    end

    assign pred_idx = pc_idx ^ IDX_W'(ghr_q);
`else
    assign pred_idx = pc_idx;
`endif

    // Predict read: old value on a same-cycle update, no bypass
    always_comb begin
        pred_ctr   = ctr_q[pred_idx];
        pred_taken = pred_ctr[CTR_W-1];
    end

    // Single next-value unit shared by the update path
    assign upd_cur = ctr_q[upd_idx];

    bp_sat_counter #(.CTR_W(CTR_W)) u_sat (
        .ctr   (upd_cur),
        .taken (upd_taken),
        .nxt   (upd_nxt)
    );

    // Counter storage: flop array so reset clears every entry at once
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= '0;
        end else if (upd_valid) begin
            for (int i = 0; i < ENTRIES; i++) begin
                if (upd_idx == IDX_W'(i)) ctr_q[i] <= upd_nxt;
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor_table.sv
// Directed bench for branch_predictor_table (default parameters).
// Define BP_GSHARE_EN for the gshare build; bimodal scenarios are skipped there.
module tb_branch_predictor_table;

    localparam int ENTRIES = 64;
    localparam int CTR_W   = 2;
    localparam int HIST_W  = 6;
    localparam int IDX_W   = 6;

    logic             clk;
    logic             reset_n;
    logic [31:0]      pred_pc;
    logic             pred_taken;
    logic [IDX_W-1:0] pred_idx;
    logic [CTR_W-1:0] pred_ctr;
    logic             upd_valid;
    logic [IDX_W-1:0] upd_idx;
    logic             upd_taken;

    int errors = 0;
    int checks = 0;

    branch_predictor_table #(
        .ENTRIES (ENTRIES),
        .CTR_W   (CTR_W),
        .HIST_W  (HIST_W)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .pred_pc    (pred_pc),
        .pred_taken (pred_taken),
        .pred_idx   (pred_idx),
        .pred_ctr   (pred_ctr),
        .upd_valid  (upd_valid),
        .upd_idx    (upd_idx),
        .upd_taken  (upd_taken)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One update across one rising edge; returns #1 after that edge
    task automatic do_update(input logic [IDX_W-1:0] idx, input logic taken);
        @(negedge clk);
        upd_valid = 1'b1;
        upd_idx   = idx;
        upd_taken = taken;
        @(posedge clk);
        #1;
        upd_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        upd_valid = 1'b0;
        upd_idx   = '0;
        upd_taken = 1'b0;
        pred_pc   = 32'h0000_0040;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (pred_ctr !== 2'd0 || pred_taken !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: ctr=%0d taken=%0b, required ctr=0 taken=0", pred_ctr, pred_taken);
        end
        checks++;
        if (pred_idx !== 6'h10) begin
            errors++;
            $display("FAIL reset_idx: idx=%h, required 10", pred_idx);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (pred_ctr !== 2'd0 || pred_taken !== 1'b0 || pred_idx !== 6'h10) begin
            errors++;
            $display("FAIL reset_release: ctr=%0d taken=%0b idx=%h, required 0 0 10", pred_ctr, pred_taken, pred_idx);
        end
    endtask

    task automatic test_sat_up();
        logic [1:0] exp_ctr [4];
        logic       exp_tk  [4];
        exp_ctr = '{2'd1, 2'd2, 2'd3, 2'd3};
        exp_tk  = '{1'b0, 1'b1, 1'b1, 1'b1};
        pred_pc = 32'h0000_0040;
        for (int i = 0; i < 4; i++) begin
            do_update(6'h10, 1'b1);
            checks++;
            if (pred_ctr !== exp_ctr[i] || pred_taken !== exp_tk[i]) begin
                errors++;
                $display("FAIL sat_up[%0d]: ctr=%0d taken=%0b, required ctr=%0d taken=%0b", i, pred_ctr, pred_taken, exp_ctr[i], exp_tk[i]);
            end
        end
    endtask

    task automatic test_sat_down();
        logic [1:0] exp_ctr [4];
        logic       exp_tk  [4];
        exp_ctr = '{2'd2, 2'd1, 2'd0, 2'd0};
        exp_tk  = '{1'b1, 1'b0, 1'b0, 1'b0};
        pred_pc = 32'h0000_0040;
        for (int i = 0; i < 4; i++) begin
            do_update(6'h10, 1'b0);
            checks++;
            if (pred_ctr !== exp_ctr[i] || pred_taken !== exp_tk[i]) begin
                errors++;
                $display("FAIL sat_down[%0d]: ctr=%0d taken=%0b, required ctr=%0d taken=%0b", i, pred_ctr, pred_taken, exp_ctr[i], exp_tk[i]);
            end
        end
    endtask

    task automatic test_isolation();
        pred_pc = 32'h0000_0014;
        @(negedge clk);
        upd_valid = 1'b1;
        upd_idx   = 6'd5;
        upd_taken = 1'b1;
        #1;
        checks++;
        if (pred_ctr !== 2'd0 || pred_idx !== 6'd5) begin
            errors++;
            $display("FAIL same_cycle_old: ctr=%0d idx=%0d, required ctr=0 idx=5", pred_ctr, pred_idx);
        end
        @(posedge clk);
        #1;
        upd_valid = 1'b0;
        checks++;
        if (pred_ctr !== 2'd1) begin
            errors++;
            $display("FAIL next_cycle_new: ctr=%0d, required 1", pred_ctr);
        end
        pred_pc = 32'h0000_0018;
        #1;
        checks++;
        if (pred_ctr !== 2'd0 || pred_idx !== 6'd6) begin
            errors++;
            $display("FAIL neighbour_hold: ctr=%0d idx=%0d, required ctr=0 idx=6", pred_ctr, pred_idx);
        end
        pred_pc = 32'h0000_0010;
        #1;
        checks++;
        if (pred_ctr !== 2'd0) begin
            errors++;
            $display("FAIL lower_neighbour_hold: ctr=%0d, required 0", pred_ctr);
        end
    endtask

    task automatic test_back_to_back();
        // Back-to-back updates to alternating entries, one per cycle
        @(negedge clk);
        upd_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            upd_idx   = (i % 2 == 0) ? 6'd1 : 6'd2;
            upd_taken = 1'b1;
            @(negedge clk);
        end
        upd_valid = 1'b0;
        pred_pc = 32'h0000_0004;
        #1;
        checks++;
        if (pred_ctr !== 2'd3) begin
            errors++;
            $display("FAIL b2b_idx1: ctr=%0d, required 3", pred_ctr);
        end
        pred_pc = 32'h0000_0008;
        #1;
        checks++;
        if (pred_ctr !== 2'd3) begin
            errors++;
            $display("FAIL b2b_idx2: ctr=%0d, required 3", pred_ctr);
        end
        // Idle cycles leave counters untouched
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (pred_ctr !== 2'd3) begin
            errors++;
            $display("FAIL idle_hold: ctr=%0d, required 3", pred_ctr);
        end
    endtask

    task automatic test_async_reset();
        int bad;
        for (int i = 0; i < 3; i++) do_update(6'd3, 1'b1);
        pred_pc = 32'h0000_000C;
        #1;
        checks++;
        if (pred_ctr !== 2'd3) begin
            errors++;
            $display("FAIL pre_reset: ctr=%0d, required 3", pred_ctr);
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (pred_ctr !== 2'd0 || pred_taken !== 1'b0) begin
            errors++;
            $display("FAIL async_clear: ctr=%0d taken=%0b, required 0 0", pred_ctr, pred_taken);
        end
        // Update presented during reset is discarded
        upd_valid = 1'b1;
        upd_idx   = 6'd3;
        upd_taken = 1'b1;
        @(posedge clk);
        #1;
        upd_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        bad = 0;
        for (int i = 0; i < ENTRIES; i++) begin
            pred_pc = 32'(i) << 2;
            #1;
            if (pred_ctr !== 2'd0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL post_reset_all_zero: %0d nonzero entries, required 0", bad);
        end
    endtask

`ifdef BP_GSHARE_EN
    task automatic test_gshare();
        do_update(6'd0, 1'b1);
        do_update(6'd0, 1'b0);
        do_update(6'd0, 1'b1);
        pred_pc = 32'h0000_0040;
        #1;
        checks++;
        if (pred_idx !== 6'h15) begin
            errors++;
            $display("FAIL gshare_idx: idx=%h, required 15", pred_idx);
        end
        checks++;
        if (pred_ctr !== 2'd0) begin
            errors++;
            $display("FAIL gshare_ctr: ctr=%0d, required 0", pred_ctr);
        end
        // pc 0x14 (slice 0x05) xor ghr 0x05 hits entry 0, last set to 1
        pred_pc = 32'h0000_0014;
        #1;
        checks++;
        if (pred_idx !== 6'h00 || pred_ctr !== 2'd1) begin
            errors++;
            $display("FAIL gshare_entry0: idx=%h ctr=%0d, required 00 1", pred_idx, pred_ctr);
        end
    endtask
`endif

    initial begin
        test_reset();
`ifdef BP_GSHARE_EN
        test_gshare();
`else
        test_sat_up();
        test_sat_down();
        test_isolation();
        test_back_to_back();
        test_async_reset();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
